// File: rtl/vc_mem_port_arbiter_2to1.sv
// ============================================================================
// vc_mem_port_arbiter_2to1
//
// Purpose:
//   Shares one single-ported test memory request/response interface between
//   two requesters. Requests are granted round-robin with zero-cycle latency.
//   The ID of each issued request is recorded in a small in-flight FIFO.
//   Responses, which the memory returns strictly in order, are steered back
//   to the issuer named at the FIFO head. Messages pass through unmodified,
//   and the opaque field is never used for routing.
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   memreq{0,1}_val_i/rdy_o/msg_i     requests from the two clients
//   memresp{0,1}_val_o/rdy_i/msg_o    responses back to the two clients
//   memreq_val_o/rdy_i/msg_o          request to the memory
//   memresp_val_i/rdy_o/msg_i         response from the memory
//   perf_grant0_o, perf_grant1_o, perf_conflict_o (16b, optional)
//
// Configuration:
//   VC_MEM_PORT_ARB_PERF_EN  when defined, adds the three saturating
//                            performance counters and their output ports.
// ============================================================================
module vc_mem_port_arbiter_2to1 #(
    parameter  int p_opaque_nbits = 8,
    parameter  int p_addr_nbits   = 32,
    parameter  int p_data_nbits   = 32,
    parameter  int p_max_inflight = 4,
    localparam int c_len_nbits    = $clog2(p_data_nbits / 8),
    localparam int c_req_nbits    = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits + p_data_nbits,
    localparam int c_resp_nbits   = 3 + p_opaque_nbits + 2 + c_len_nbits + p_data_nbits
) (
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic                    memreq0_val_i,
    output logic                    memreq0_rdy_o,
    input  logic [c_req_nbits-1:0]  memreq0_msg_i,
    input  logic                    memreq1_val_i,
    output logic                    memreq1_rdy_o,
    input  logic [c_req_nbits-1:0]  memreq1_msg_i,

    output logic                    memresp0_val_o,
    input  logic                    memresp0_rdy_i,
    output logic [c_resp_nbits-1:0] memresp0_msg_o,
    output logic                    memresp1_val_o,
    input  logic                    memresp1_rdy_i,
    output logic [c_resp_nbits-1:0] memresp1_msg_o,

    output logic                    memreq_val_o,
    input  logic                    memreq_rdy_i,
    output logic [c_req_nbits-1:0]  memreq_msg_o,

    input  logic                    memresp_val_i,
    output logic                    memresp_rdy_o,
    input  logic [c_resp_nbits-1:0] memresp_msg_i
`ifdef VC_MEM_PORT_ARB_PERF_EN
    ,
    output logic [15:0]             perf_grant0_o,
    output logic [15:0]             perf_grant1_o,
    output logic [15:0]             perf_conflict_o
`endif
);

    localparam int c_ptr_nbits = $clog2(p_max_inflight);
    localparam int c_cnt_nbits = c_ptr_nbits + 1;

    logic                      prioPtr_q, prioPtr_d;
    logic [c_ptr_nbits-1:0]    head_q, head_d;
    logic [c_ptr_nbits-1:0]    tail_q, tail_d;
    logic [c_cnt_nbits-1:0]    count_q, count_d;
    logic [p_max_inflight-1:0] idFifo_q, idFifo_d;

    logic anyReq, bothReq, winner, fifoFull, fifoEmpty, canIssue;
    logic headId, reqFire, respFire;

    // Request side: grant and handshake are purely combinational. The full
    // check deliberately ignores a same-cycle pop so that memresp_rdy never
    // feeds memreq_rdy combinationally.
    always_comb begin
        anyReq    = memreq0_val_i | memreq1_val_i;
        bothReq   = memreq0_val_i & memreq1_val_i;
        winner    = bothReq ? prioPtr_q : memreq1_val_i;
        fifoFull  = (count_q == c_cnt_nbits'(p_max_inflight));
        fifoEmpty = (count_q == '0);
        canIssue  = !fifoFull && memreq_rdy_i;

        memreq_val_o  = !reset_i && anyReq && !fifoFull;
        memreq_msg_o  = winner ? memreq1_msg_i : memreq0_msg_i;
        memreq0_rdy_o = !reset_i && !winner && canIssue;
        memreq1_rdy_o = !reset_i &&  winner && canIssue;
        reqFire       = memreq_val_o && memreq_rdy_i;
    end

    // Response side: only the client named at the FIFO head may see a valid
    // response, so a stalled head client blocks the other (no reordering).
    always_comb begin
        headId         = idFifo_q[head_q];
        memresp0_val_o = !reset_i && !fifoEmpty && !headId && memresp_val_i;
        memresp1_val_o = !reset_i && !fifoEmpty &&  headId && memresp_val_i;
        memresp_rdy_o  = !reset_i && !fifoEmpty && (headId ? memresp1_rdy_i : memresp0_rdy_i);
        memresp0_msg_o = memresp_msg_i;
        memresp1_msg_o = memresp_msg_i;
        respFire       = memresp_val_i && memresp_rdy_o;
    end

    // Next state for the priority pointer and the in-flight ID FIFO.
    always_comb begin
        prioPtr_d = prioPtr_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        idFifo_d  = idFifo_q;

        if (reqFire) begin
            idFifo_d[tail_q] = winner;
            tail_d           = tail_q + c_ptr_nbits'(1);
            prioPtr_d        = !winner;
        end
        if (respFire) begin
            head_d = head_q + c_ptr_nbits'(1);
        end
        case ({reqFire, respFire})
            2'b10:   count_d = count_q + c_cnt_nbits'(1);
            2'b01:   count_d = count_q - c_cnt_nbits'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prioPtr_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            idFifo_q  <= '0;
        end else begin
            prioPtr_q <= prioPtr_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            idFifo_q  <= idFifo_d;
        end
    end

`ifdef VC_MEM_PORT_ARB_PERF_EN
    logic [15:0] grant0_q, grant1_q, conflict_q;

    // Saturating event counters; they never wrap back to zero.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            grant0_q   <= '0;
            grant1_q   <= '0;
            conflict_q <= '0;
        end else begin
            if (reqFire && !winner && grant0_q != 16'hFFFF) grant0_q <= grant0_q + 16'd1;
            if (reqFire &&  winner && grant1_q != 16'hFFFF) grant1_q <= grant1_q + 16'd1;
            if (reqFire && bothReq && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
        end
    end

    assign perf_grant0_o   = grant0_q;
    assign perf_grant1_o   = grant1_q;
    assign perf_conflict_o = conflict_q;
`endif

    // A response with nothing in flight has no destination; flag it rather
    // than silently dropping it.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!$isunknown({memreq0_val_i, memreq1_val_i, memreq_rdy_i,
                                 memresp_val_i, memresp0_rdy_i, memresp1_rdy_i}));
            assert (!(memresp_val_i && fifoEmpty));
        end
    end

endmodule

// File: tb/tb_vc_mem_port_arbiter_2to1.sv
// ============================================================================
// tb_vc_mem_port_arbiter_2to1
//
// Purpose:
//   Self-checking bench for vc_mem_port_arbiter_2to1. A behavioural model
//   (queue of issuer IDs, a "who goes next" flag and an in-order memory
//   queue) predicts every output each cycle. Directed sequences pin the
//   model with hand-computed values, then randomized traffic runs.
// ============================================================================
`timescale 1ns/1ps
module tb_vc_mem_port_arbiter_2to1;

    localparam int REQ  = 77;
    localparam int RESP = 47;
    localparam int MAXQ = 4;
    localparam logic [REQ-1:0] REQ0 = {3'd0, 8'h11, 32'h0000_0100, 2'd0, 32'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            req0Val, req0Rdy, req1Val, req1Rdy;
    logic [REQ-1:0]  req0Msg, req1Msg;
    logic            resp0Val, resp0Rdy, resp1Val, resp1Rdy;
    logic [RESP-1:0] resp0Msg, resp1Msg;
    logic            memReqVal, memReqRdy;
    logic [REQ-1:0]  memReqMsg;
    logic            memRespVal, memRespRdy;
    logic [RESP-1:0] memRespMsg;
`ifdef VC_MEM_PORT_ARB_PERF_EN
    logic [15:0]     perfGrant0, perfGrant1, perfConflict;
`endif

    vc_mem_port_arbiter_2to1 dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .memreq0_val_i  (req0Val),
        .memreq0_rdy_o  (req0Rdy),
        .memreq0_msg_i  (req0Msg),
        .memreq1_val_i  (req1Val),
        .memreq1_rdy_o  (req1Rdy),
        .memreq1_msg_i  (req1Msg),
        .memresp0_val_o (resp0Val),
        .memresp0_rdy_i (resp0Rdy),
        .memresp0_msg_o (resp0Msg),
        .memresp1_val_o (resp1Val),
        .memresp1_rdy_i (resp1Rdy),
        .memresp1_msg_o (resp1Msg),
        .memreq_val_o   (memReqVal),
        .memreq_rdy_i   (memReqRdy),
        .memreq_msg_o   (memReqMsg),
        .memresp_val_i  (memRespVal),
        .memresp_rdy_o  (memRespRdy),
        .memresp_msg_i  (memRespMsg)
`ifdef VC_MEM_PORT_ARB_PERF_EN
        ,
        .perf_grant0_o  (perfGrant0),
        .perf_grant1_o  (perfGrant1),
        .perf_conflict_o(perfConflict)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: issuer IDs in issue order, memory response queue with
    // ready times, and which port wins the next contested cycle.
    bit              idq[$];
    logic [RESP-1:0] memQ[$];
    int              memT[$];
    bit              mPrio;
    bit              memEn;
    int              lat;
    int              mGrant0, mGrant1, mConf;
    int              recv0, recv1;
    int              errors = 0;
    int              checks = 0;

    function automatic logic [REQ-1:0] randReq();
        return REQ'({$urandom, $urandom, $urandom});
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the clock edge; the memory model
    // presents its oldest response once its latency has elapsed.
    task automatic applyStimulus(input logic v0, input logic v1,
                                 input logic [REQ-1:0] m0, input logic [REQ-1:0] m1,
                                 input logic reqRdy, input logic r0, input logic r1);
        @(posedge clk);
        #1;
        req0Val = v0; req1Val = v1; req0Msg = m0; req1Msg = m1;
        memReqRdy = reqRdy; resp0Rdy = r0; resp1Rdy = r1;
        if (memEn && memQ.size() > 0 && cyc >= memT[0]) begin
            memRespVal = 1'b1;
            memRespMsg = memQ[0];
        end else begin
            memRespVal = 1'b0;
            memRespMsg = RESP'({$urandom, $urandom});
        end
        #3;
    endtask

    // Compare every output against the model, then advance the model by
    // the handshakes the model itself says happen this cycle.
    task automatic checkOutput();
        bit anyReq, win, full, expReqVal, headValid, h, expRespRdy, reqFire, respFire;
        anyReq     = req0Val || req1Val;
        win        = (req0Val && req1Val) ? mPrio : req1Val;
        full       = (idq.size() == MAXQ);
        expReqVal  = anyReq && !full;
        headValid  = (idq.size() > 0);
        h          = headValid ? idq[0] : 1'b0;
        expRespRdy = headValid && (h ? resp1Rdy : resp0Rdy);

        chk("memreq_val", memReqVal, expReqVal);
        if (anyReq) begin
            chk("memreq0_rdy", req0Rdy, expReqVal && memReqRdy && !win);
            chk("memreq1_rdy", req1Rdy, expReqVal && memReqRdy && win);
        end
        if (expReqVal) chk("memreq_msg", memReqMsg, win ? req1Msg : req0Msg);
        chk("memresp0_val", resp0Val, headValid && !h && memRespVal);
        chk("memresp1_val", resp1Val, headValid &&  h && memRespVal);
        chk("memresp_rdy", memRespRdy, expRespRdy);
        chk("memresp0_msg", resp0Msg, memRespMsg);
        chk("memresp1_msg", resp1Msg, memRespMsg);
`ifdef VC_MEM_PORT_ARB_PERF_EN
        chk("perf_grant0", perfGrant0, 16'(mGrant0));
        chk("perf_grant1", perfGrant1, 16'(mGrant1));
        chk("perf_conflict", perfConflict, 16'(mConf));
`endif
        if (resp0Val && resp0Rdy) recv0++;
        if (resp1Val && resp1Rdy) recv1++;

        reqFire  = expReqVal && memReqRdy;
        respFire = memRespVal && expRespRdy;
        if (respFire) begin
            void'(idq.pop_front());
            void'(memQ.pop_front());
            void'(memT.pop_front());
        end
        if (reqFire) begin
            idq.push_back(win);
            memQ.push_back(RESP'({$urandom, $urandom}));
            memT.push_back(cyc + lat);
            mPrio = !win;
            if (!win && mGrant0 < 65535) mGrant0++;
            if ( win && mGrant1 < 65535) mGrant1++;
            if (req0Val && req1Val && mConf < 65535) mConf++;
        end
    endtask

    task automatic step(input logic v0, input logic v1, input logic reqRdy,
                        input logic r0, input logic r1);
        applyStimulus(v0, v1, randReq(), randReq(), reqRdy, r0, r1);
        checkOutput();
    endtask

    // Reset with all inputs active: every val/rdy output must drop at once.
    task automatic doReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req0Val = 1'b1; req1Val = 1'b1; memReqRdy = 1'b1;
        memRespVal = 1'b1; resp0Rdy = 1'b1; resp1Rdy = 1'b1;
        #1;
        chk("rst_memreq_val", memReqVal, 1'b0);
        chk("rst_memreq0_rdy", req0Rdy, 1'b0);
        chk("rst_memreq1_rdy", req1Rdy, 1'b0);
        chk("rst_memresp0_val", resp0Val, 1'b0);
        chk("rst_memresp1_val", resp1Val, 1'b0);
        chk("rst_memresp_rdy", memRespRdy, 1'b0);
`ifdef VC_MEM_PORT_ARB_PERF_EN
        chk("rst_perf_grant0", perfGrant0, 16'd0);
        chk("rst_perf_grant1", perfGrant1, 16'd0);
        chk("rst_perf_conflict", perfConflict, 16'd0);
`endif
        @(posedge clk);
        #1;
        req0Val = 1'b0; req1Val = 1'b0; memReqRdy = 1'b0;
        memRespVal = 1'b0; resp0Rdy = 1'b0; resp1Rdy = 1'b0;
        reset = 1'b0;
        idq.delete(); memQ.delete(); memT.delete();
        mPrio = 1'b0; mGrant0 = 0; mGrant1 = 0; mConf = 0;
    endtask

    task automatic drain();
        memEn = 1'b1;
        for (int i = 0; i < 200 && idq.size() > 0; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("drain_inflight", 32'(idq.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r0Base, r1Base;
        reset = 1'b1;
        req0Val = 1'b0; req1Val = 1'b0; req0Msg = '0; req1Msg = '0;
        memReqRdy = 1'b0; memRespVal = 1'b0; memRespMsg = '0;
        resp0Rdy = 1'b0; resp1Rdy = 1'b0;
        memEn = 1'b1; lat = 1;
        doReset();

        // Port 0 alone, address 0x100, memory ready.
        applyStimulus(1'b1, 1'b0, REQ0, randReq(), 1'b1, 1'b1, 1'b1);
        chk("t1_memreq_val", memReqVal, 1'b1);
        chk("t1_memreq_msg", memReqMsg, REQ0);
        chk("t1_memreq0_rdy", req0Rdy, 1'b1);
        chk("t1_memreq1_rdy", req1Rdy, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, randReq(), randReq(), 1'b1, 1'b1, 1'b1);
        chk("t1_memresp0_val", resp0Val, 1'b1);
        chk("t1_memresp1_val", resp1Val, 1'b0);
        checkOutput();
        drain();

        // Both ports valid every cycle: grants alternate starting with 0.
        doReset();
        lat = 2;
        r0Base = recv0; r1Base = recv1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1, randReq(), randReq(), 1'b1, 1'b1, 1'b1);
            chk("t2_memreq0_rdy", req0Rdy, (i % 2) == 0);
            chk("t2_memreq1_rdy", req1Rdy, (i % 2) == 1);
            checkOutput();
        end
        drain();
        chk("t2_recv0", 32'(recv0 - r0Base), 32'd6);
        chk("t2_recv1", 32'(recv1 - r1Base), 32'd6);

        // Memory stalls for 3 cycles: no fire, port 0 still next in line.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, randReq(), randReq(), 1'b0, 1'b1, 1'b1);
            chk("t3_stall_val", memReqVal, 1'b1);
            chk("t3_stall_rdy0", req0Rdy, 1'b0);
            chk("t3_stall_rdy1", req1Rdy, 1'b0);
            checkOutput();
        end
        applyStimulus(1'b1, 1'b1, randReq(), randReq(), 1'b1, 1'b1, 1'b1);
        chk("t3_after_rdy0", req0Rdy, 1'b1);
        checkOutput();
        drain();

        // Fill the in-flight FIFO, then check the pop cycle stays blocked.
        memEn = 1'b0; lat = 1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, randReq(), randReq(), 1'b1, 1'b1, 1'b1);
            chk("t4_fill_rdy0", req0Rdy, 1'b1);
            checkOutput();
        end
        applyStimulus(1'b1, 1'b0, randReq(), randReq(), 1'b1, 1'b1, 1'b1);
        chk("t4_full_rdy0", req0Rdy, 1'b0);
        chk("t4_full_val", memReqVal, 1'b0);
        checkOutput();
        memEn = 1'b1;
        applyStimulus(1'b1, 1'b0, randReq(), randReq(), 1'b1, 1'b1, 1'b1);
        chk("t4_pop_resprdy", memRespRdy, 1'b1);
        chk("t4_pop_rdy0", req0Rdy, 1'b0);
        checkOutput();
        memEn = 1'b0;
        applyStimulus(1'b1, 1'b0, randReq(), randReq(), 1'b1, 1'b1, 1'b1);
        chk("t4_next_rdy0", req0Rdy, 1'b1);
        checkOutput();

        // Head belongs to port 0 which is not ready: port 1 must not see it.
        memEn = 1'b1;
        applyStimulus(1'b0, 1'b0, randReq(), randReq(), 1'b1, 1'b0, 1'b1);
        chk("t5_memresp_rdy", memRespRdy, 1'b0);
        chk("t5_memresp0_val", resp0Val, 1'b1);
        chk("t5_memresp1_val", resp1Val, 1'b0);
        checkOutput();

        // Reset with requests in flight, then port 0 favoured and not full.
        doReset();
        applyStimulus(1'b1, 1'b1, randReq(), randReq(), 1'b1, 1'b1, 1'b1);
        chk("t6_memreq_val", memReqVal, 1'b1);
        chk("t6_memreq0_rdy", req0Rdy, 1'b1);
        chk("t6_memreq1_rdy", req1Rdy, 1'b0);
        checkOutput();

        // Randomized traffic with varied densities and latencies.
        for (int ph = 0; ph < 6; ph++) begin
            int p0, p1, pRdy, pR0, pR1, pMem;
            p0   = $urandom_range(100, 20);
            p1   = $urandom_range(100, 20);
            pRdy = $urandom_range(100, 30);
            pR0  = $urandom_range(100, 40);
            pR1  = $urandom_range(100, 40);
            pMem = $urandom_range(100, 50);
            if (ph == 3) doReset();
            for (int c = 0; c < 600; c++) begin
                lat   = $urandom_range(8, 1);
                memEn = ($urandom_range(99) < pMem);
                step($urandom_range(99) < p0, $urandom_range(99) < p1,
                     $urandom_range(99) < pRdy, $urandom_range(99) < pR0,
                     $urandom_range(99) < pR1);
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
